// File: rtl/burst_pkg.sv
// Shared types and constants for the cache-line to memory-burst adaptor.
// Holds the FSM state encoding and the beat-count geometry of one line.
package burst_pkg;

    // Beats per cache line and the width of the beat index.
    localparam int BEATS      = 4;
    localparam int BEAT_IDX_W = $clog2(BEATS);

    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

    // Line transfer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } burst_state_t;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Converts cache line read/write requests into fixed-length memory bursts.
// Every output is registered; read data becomes visible only once complete.
module cacheline_burst_adaptor
    import burst_pkg::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    // Line-aligned address mask (32-byte lines).
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFE0;

    burst_state_t          r_state;
    burst_state_t          w_state;
    beat_idx_t             r_cnt;
    beat_idx_t             w_cnt;
    beat_idx_t             w_cnt_inc;
    logic                  r_last;
    logic [LINE_WIDTH-1:0] r_wr_line;
    logic [LINE_WIDTH-1:0] w_wr_line;
    logic [LINE_WIDTH-1:0] r_rd_line;
    logic [LINE_WIDTH-1:0] w_rd_line;
    logic [LINE_WIDTH-1:0] w_line;
    logic [31:0]           w_addr;
    logic                  w_read;
    logic                  w_write;
    logic                  w_resp;
    logic [BURST_WIDTH-1:0] w_burst;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign r_last    = (r_cnt == LAST_BEAT);

    // Next-state and next-output decode for the transfer FSM.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_wr_line = r_wr_line;
        w_rd_line = r_rd_line;
        w_line    = line_o;
        w_addr    = address_o;
        w_read    = read_o;
        w_write   = write_o;
        w_resp    = 1'b0;
        w_burst   = burst_o;
        unique case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_state   = WR_BURST;
                    w_cnt     = '0;
                    w_addr    = address_i & ADDR_MASK;
                    w_write   = 1'b1;
                    w_wr_line = line_i;
                    w_burst   = line_i[BURST_WIDTH-1:0];
                end else if (read_i) begin
                    w_state = RD_BURST;
                    w_cnt   = '0;
                    w_addr  = address_i & ADDR_MASK;
                    w_read  = 1'b1;
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    w_rd_line[int'(r_cnt)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                    if (r_last) begin
                        w_state = DONE;
                        w_read  = 1'b0;
                        w_resp  = 1'b1;
                        w_line  = w_rd_line;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
            end
            WR_BURST: begin
                if (resp_i) begin
                    if (r_last) begin
                        w_state = DONE;
                        w_write = 1'b0;
                        w_resp  = 1'b1;
                        w_burst = '0;
                    end else begin
                        w_cnt   = w_cnt_inc;
                        w_burst = r_wr_line[int'(w_cnt_inc)*BURST_WIDTH +: BURST_WIDTH];
                    end
                end
            end
            DONE: begin
                w_state = IDLE;
                w_cnt   = '0;
            end
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    // State, counter, line buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wr_line <= '0;
            r_rd_line <= '0;
            line_o    <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
            burst_o   <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_wr_line <= w_wr_line;
            r_rd_line <= w_rd_line;
            line_o    <= w_line;
            address_o <= w_addr;
            read_o    <= w_read;
            write_o   <= w_write;
            resp_o    <= w_resp;
            burst_o   <= w_burst;
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for the cache-line burst adaptor.
// Expected values are hand-computed constants checked with immediate asserts.
module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int n_vec = 0;
    int n_err = 0;

    cacheline_burst_adaptor #(
        .LINE_WIDTH (256),
        .BURST_WIDTH(64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    localparam logic [255:0] RD_LINE1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    localparam logic [255:0] WR_LINE  = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    localparam logic [255:0] RD_LINE2 = {{16{4'hA}}, {16{4'h9}}, {16{4'h8}}, {16{4'h7}}};
    localparam logic [255:0] RD_LINE3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                         64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
    localparam logic [255:0] RD_LINE4 = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                                         64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};

    // Feeds four back-to-back read beats from data, starting in burst cycle 1.
    task automatic feed_read(input logic [255:0] data, input string tag);
        for (int b = 0; b < 4; b++) begin
            chk({tag, " read_o"}, {255'd0, read_o}, 256'd1);
            chk({tag, " resp_o busy"}, {255'd0, resp_o}, 256'd0);
            resp_i  = 1'b1;
            burst_i = data[b*64 +: 64];
            tick();
        end
        resp_i = 1'b0;
        chk({tag, " resp_o"}, {255'd0, resp_o}, 256'd1);
        chk({tag, " read_o end"}, {255'd0, read_o}, 256'd0);
        chk({tag, " line_o"}, line_o, data);
    endtask

    initial begin
        int wr_hi;
        int n_resp;
        logic [255:0] line_a;

        rst_n     = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        tick();
        tick();
        chk("rst read_o", {255'd0, read_o}, 256'd0);
        chk("rst write_o", {255'd0, write_o}, 256'd0);
        chk("rst resp_o", {255'd0, resp_o}, 256'd0);
        chk("rst address_o", {224'd0, address_o}, 256'd0);
        chk("rst burst_o", {192'd0, burst_o}, 256'd0);
        chk("rst line_o", line_o, 256'd0);
        rst_n = 1'b1;
        tick();

        resp_i  = 1'b1;
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle resp_i read_o", {255'd0, read_o}, 256'd0);
            chk("idle resp_i resp_o", {255'd0, resp_o}, 256'd0);
            chk("idle resp_i line_o", line_o, 256'd0);
        end
        resp_i = 1'b0;

        address_i = 32'h0000_1234;
        read_i    = 1'b1;
        tick();
        chk("rd address_o", {224'd0, address_o}, {224'd0, 32'h0000_1220});
        address_i = 32'hFFFF_FFFF;
        feed_read(RD_LINE1, "rd1");
        chk("rd address_o held", {224'd0, address_o}, {224'd0, 32'h0000_1220});
        read_i = 1'b0;
        tick();
        chk("rd1 resp_o pulse", {255'd0, resp_o}, 256'd0);
        chk("rd1 line_o kept", line_o, RD_LINE1);

        address_i = 32'h8000_003F;
        line_i    = WR_LINE;
        write_i   = 1'b1;
        tick();
        chk("wr address_o", {224'd0, address_o}, {224'd0, 32'h8000_0020});
        line_i = '0;
        wr_hi  = 0;
        n_resp = 0;
        for (int c = 1; c <= 8; c++) begin
            if (write_o) wr_hi++;
            if (resp_o) n_resp++;
            chk("wr burst_o", {192'd0, burst_o}, {192'd0, WR_LINE[((c-1)/2)*64 +: 64]});
            resp_i = (c % 2 == 0);
            tick();
        end
        resp_i = 1'b0;
        chk("wr write_o cycles", wr_hi, 8);
        chk("wr resp_o early", n_resp, 0);
        chk("wr resp_o", {255'd0, resp_o}, 256'd1);
        chk("wr write_o end", {255'd0, write_o}, 256'd0);
        chk("wr line_o kept", line_o, RD_LINE1);
        write_i = 1'b0;
        tick();
        chk("wr resp_o pulse", {255'd0, resp_o}, 256'd0);

        address_i = 32'h0000_0100;
        line_i    = RD_LINE3;
        read_i    = 1'b1;
        write_i   = 1'b1;
        tick();
        line_i = '0;
        for (int c = 1; c <= 4; c++) begin
            chk("both read_o", {255'd0, read_o}, 256'd0);
            chk("both write_o", {255'd0, write_o}, 256'd1);
            chk("both burst_o", {192'd0, burst_o}, {192'd0, RD_LINE3[(c-1)*64 +: 64]});
            resp_i = 1'b1;
            tick();
        end
        resp_i = 1'b0;
        chk("both resp_o", {255'd0, resp_o}, 256'd1);
        chk("both read_o end", {255'd0, read_o}, 256'd0);
        read_i  = 1'b0;
        write_i = 1'b0;
        tick();

        address_i = 32'h0000_0040;
        read_i    = 1'b1;
        tick();
        resp_i  = 1'b1;
        burst_i = {16{4'h5}};
        tick();
        burst_i = {16{4'h6}};
        tick();
        resp_i = 1'b0;
        chk("abort read_o pre", {255'd0, read_o}, 256'd1);
        rst_n = 1'b0;
        #1;
        chk("abort read_o", {255'd0, read_o}, 256'd0);
        chk("abort address_o", {224'd0, address_o}, 256'd0);
        chk("abort line_o", line_o, 256'd0);
        read_i = 1'b0;
        resp_i = 1'b1;
        n_resp = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (resp_o) n_resp++;
        end
        rst_n  = 1'b1;
        resp_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (resp_o) n_resp++;
        end
        chk("abort no resp_o", n_resp, 0);
        address_i = 32'h0000_0055;
        read_i    = 1'b1;
        tick();
        chk("fresh address_o", {224'd0, address_o}, {224'd0, 32'h0000_0040});
        feed_read(RD_LINE2, "fresh");
        read_i = 1'b0;
        tick();

        address_i = 32'h0000_2000;
        read_i    = 1'b1;
        tick();
        feed_read(RD_LINE3, "hold1");
        line_a = line_o;
        tick();
        chk("hold gap read_o", {255'd0, read_o}, 256'd0);
        chk("hold gap resp_o", {255'd0, resp_o}, 256'd0);
        tick();
        chk("hold rearm read_o", {255'd0, read_o}, 256'd1);
        chk("hold line_o partial", line_o, line_a);
        read_i = 1'b0;
        feed_read(RD_LINE4, "hold2");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cacheline_burst_adaptor.md
CACHELINE_BURST_ADAPTOR -- requirements
Module: cacheline_burst_adaptor

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 256, cache-line width in bits.
REQ-002 SHALL have parameter BURST_WIDTH, default 64, memory beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH (4).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port line_i, input, LINE_WIDTH, write-back line from cache.
REQ-006 SHALL have port line_o, output, LINE_WIDTH, fill line to cache.
REQ-007 SHALL have port address_i, input, 32, cache line address.
REQ-008 SHALL have port read_i, input, 1, cache line-read request.
REQ-009 SHALL have port write_i, input, 1, cache line-write request.
REQ-010 SHALL have port resp_o, output, 1, one-cycle line-transfer-complete pulse.
REQ-011 SHALL have port burst_i, input, BURST_WIDTH, read beat from memory.
REQ-012 SHALL have port burst_o, output, BURST_WIDTH, write beat to memory.
REQ-013 SHALL have port address_o, output, 32, line-aligned memory address.
REQ-014 SHALL have port read_o, output, 1, memory burst-read request.
REQ-015 SHALL have port write_o, output, 1, memory burst-write request.
REQ-016 SHALL have port resp_i, input, 1, memory beat valid/accepted strobe.

Function
REQ-017 SHALL implement FSM states IDLE, RD_BURST, WR_BURST, DONE; all outputs registered.
REQ-018 SHALL sample read_i/write_i only in IDLE; write_i has priority when both high.
REQ-019 On accept: SHALL latch address_i with bits [4:0] forced to 0 into address_o, clear beat counter, go to RD_BURST (read_o=1) or WR_BURST (write_o=1, line_i latched) next cycle.
REQ-020 In RD_BURST, each cycle with resp_i=1 SHALL store burst_i into line bits [64*cnt+63:64*cnt] and increment cnt; resp_i=0 stalls.
REQ-021 In WR_BURST, burst_o SHALL equal latched line beat cnt (beat 0 = bits [63:0]); each resp_i=1 advances cnt.
REQ-022 On beat BEATS-1 with resp_i=1 SHALL deassert read_o/write_o next cycle and enter DONE.
REQ-023 In DONE SHALL assert resp_o for exactly one cycle, line_o holding the assembled line (read), then return to IDLE.
REQ-024 Minimum read/write latency: request at cycle 0, read_o/write_o high cycles 1-4 with resp_i continuously high, resp_o at cycle 5.
REQ-025 resp_i in IDLE or DONE SHALL be ignored; no state change.
REQ-026 Requests still high in DONE SHALL not be re-accepted until IDLE; cache deasserts on resp_o.
REQ-027 line_o SHALL retain the last completed read line until next read completes; partial reads never visible.
REQ-028 address_o SHALL be stable for the whole burst regardless of address_i changes.
REQ-029 Beat counter SHALL be log2(BEATS) bits and never wrap mid-transfer.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, cnt=0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0.
REQ-031 Reset mid-burst SHALL abort the transfer; no resp_o issued; first request after release starts a fresh burst.

Structure
REQ-032 SHALL place the state enum, BEATS and beat-index width in shared package burst_pkg.
REQ-033 SHALL be a single module; no sub-module.

Verification
REQ-034 Read: address_i=0x0000_1234, memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> address_o=0x0000_1220, resp_o at cycle 5, line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-035 Write: line_i=256'hDDDD..CCCC..BBBB..AAAA (beat0=AAAA..) with resp_i gapped one cycle between beats -> burst_o AAAA,BBBB,CCCC,DDDD in order, write_o high 8 cycles, single resp_o.
REQ-036 read_i=write_i=1 in same cycle -> write burst only, read_o stays 0.
REQ-037 rst_n low after 2nd read beat -> outputs zero asynchronously, no resp_o; subsequent read completes correctly.
REQ-038 resp_i=1 while IDLE for 3 cycles -> no state change, outputs unchanged.
REQ-039 read_i held high through DONE -> second burst starts only after IDLE, read_o low for ≥1 cycle between bursts.
